// File: rtl/video_pkg.sv
// Shared video-mode constants, coordinate type and total-size helpers.
// Latency: none (compile-time definitions only).
// Backpressure: none; the raster consumers cannot stall the timing.
package video_pkg;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  // 640x480 @ ~72.8 Hz from a 31.5 MHz pixel clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 24;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BACK   = 128;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 9;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BACK   = 28;

  function automatic int h_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int v_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel/fetch stages.
// Latency: n/a (wires only).
// Backpressure: none; consumers must accept every cycle.
interface vga_timing_gen_if;
  import video_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   de;
  coord_t x;
  coord_t y;
  logic   line_start;
  logic   frame_start;
  logic   vblank;
  logic   fetch_valid;
  coord_t fetch_x;
  coord_t fetch_y;

  modport master (
    output hsync, vsync, de, x, y, line_start, frame_start, vblank,
    output fetch_valid, fetch_x, fetch_y
  );

  modport slave (
    input hsync, vsync, de, x, y, line_start, frame_start, vblank,
    input fetch_valid, fetch_x, fetch_y
  );

endinterface

// File: rtl/raster_counter.sv
// Free-running x/y raster position counter with end-of-line/frame wrap.
// Latency: position advances by one every clock after reset release.
// Backpressure: none; there is no stall input.
module raster_counter
  import video_pkg::*;
#(
  parameter int H_TOTAL = 832,
  parameter int V_TOTAL = 520,
  parameter int START_X = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  output coord_t x,
  output coord_t y
);

  localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t X_INIT = coord_t'(START_X);

  // Step one position per clock; the last pixel of the last line wraps to (0, 0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= X_INIT;
      y <= '0;
    end else if (x == X_LAST) begin
      x <= '0;
      y <= (y == Y_LAST) ? '0 : y + coord_t'(1);
    end else begin
      x <= x + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: syncs, display enable, position and a look-ahead fetch position.
// Latency: every output registered; fetch_* leads x/y/de by LOOKAHEAD clocks.
// Backpressure: none; the raster is free-running.
module vga_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LOOKAHEAD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vid
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam coord_t LA_C     = coord_t'(LOOKAHEAD);

  // Mode sanity: the 10-bit counters must hold every position
  if (H_TOTAL > COORD_MAX) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL %0d exceeds coordinate range", H_TOTAL);
  end
  if (V_TOTAL > COORD_MAX) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL %0d exceeds coordinate range", V_TOTAL);
  end
  if (LOOKAHEAD < 1 || LOOKAHEAD > 8) begin : g_bad_lookahead
    $error("vga_timing_gen: LOOKAHEAD %0d outside 1..8", LOOKAHEAD);
  end

  coord_t disp_x;
  coord_t disp_y;
  coord_t fet_x;
  coord_t fet_y;

  // Counter pair holding the position the output registers will show next
  raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .START_X (0)
  ) u_disp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (disp_x),
    .y     (disp_y)
  );

  // Second pair started LOOKAHEAD positions ahead; same wrap rules keep the lead exact
  raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .START_X (LOOKAHEAD)
  ) u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (fet_x),
    .y     (fet_y)
  );

  logic hs_act;
  logic vs_act;
  logic disp_vis;
  logic fet_vis;

  // Region decode from the counters, so each output register sees the same position
  always_comb begin
    hs_act   = (disp_x >= HS_FIRST) && (disp_x <= HS_LAST);
    vs_act   = (disp_y >= VS_FIRST) && (disp_y <= VS_LAST);
    disp_vis = (disp_x < H_ACT_C) && (disp_y < V_ACT_C);
    fet_vis  = (fet_x < H_ACT_C) && (fet_y < V_ACT_C);
  end

  // Output registers; reset drives syncs inactive and blanks everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.x           <= '0;
      vid.y           <= '0;
      vid.de          <= 1'b0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.vblank      <= 1'b0;
      vid.hsync       <= ~HSYNC_POL;
      vid.vsync       <= ~VSYNC_POL;
      vid.fetch_x     <= LA_C;
      vid.fetch_y     <= '0;
      vid.fetch_valid <= 1'b0;
    end else begin
      vid.x           <= disp_x;
      vid.y           <= disp_y;
      vid.de          <= disp_vis;
      vid.line_start  <= (disp_x == '0);
      vid.frame_start <= (disp_x == '0) && (disp_y == '0);
      vid.vblank      <= (disp_y >= V_ACT_C);
      vid.hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vid.vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      vid.fetch_x     <= fet_x;
      vid.fetch_y     <= fet_y;
      vid.fetch_valid <= fet_vis;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default mode (LOOKAHEAD 2) plus a scaled-down mode
// (25x17 raster, LOOKAHEAD 5 and 2) so several whole frames fit in a short run.
// Expected outputs come from an arithmetic model: position = clocks since release mod frame.
module tb_vga_timing_gen;

  // Scaled mode: H 16+2+3+4 = 25, V 10+2+2+3 = 17, frame 425 clocks
  localparam int SH_A = 16, SH_F = 2, SH_S = 3, SH_B = 4;
  localparam int SV_A = 10, SV_F = 2, SV_S = 2, SV_B = 3;

  typedef struct {
    int x, y, hs, vs, de, ls, fs, vb, fv, fx, fy;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   edges    = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if ifa();
  vga_timing_gen_if ifb();
  vga_timing_gen_if ifc();

  vga_timing_gen #(.LOOKAHEAD(2)) dut_a (.clk(clk), .rst_n(rst_n), .vid(ifa));

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_ACTIVE(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
    .LOOKAHEAD(5)
  ) dut_b (.clk(clk), .rst_n(rst_n), .vid(ifb));

  vga_timing_gen #(
    .H_ACTIVE(SH_A), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
    .V_ACTIVE(SV_A), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
    .LOOKAHEAD(2)
  ) dut_c (.clk(clk), .rst_n(rst_n), .vid(ifc));

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the raster is a pure function of how many clocks have elapsed since release
  function automatic obs_t model(input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vbk,
                                 input int la, input int p, input bit in_rst);
    obs_t e;
    int ht, vt, q, fq;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vbk;
    if (in_rst) begin
      e = '{x:0, y:0, hs:1, vs:1, de:0, ls:0, fs:0, vb:0, fv:0, fx:la, fy:0};
      return e;
    end
    q    = p % (ht * vt);
    e.x  = q % ht;
    e.y  = q / ht;
    e.hs = (e.x >= ha + hf && e.x < ha + hf + hsw) ? 0 : 1;
    e.vs = (e.y >= va + vf && e.y < va + vf + vsw) ? 0 : 1;
    e.de = (e.x < ha && e.y < va) ? 1 : 0;
    e.ls = (e.x == 0) ? 1 : 0;
    e.fs = (q == 0) ? 1 : 0;
    e.vb = (e.y >= va) ? 1 : 0;
    fq   = (q + la) % (ht * vt);
    e.fx = fq % ht;
    e.fy = fq / ht;
    e.fv = (e.fx < ha && e.fy < va) ? 1 : 0;
    return e;
  endfunction

  function automatic obs_t sample(input logic [9:0] x, input logic [9:0] y,
                                  input logic [9:0] fx, input logic [9:0] fy,
                                  input logic hs, input logic vs, input logic de,
                                  input logic ls, input logic fs, input logic vb,
                                  input logic fv);
    obs_t o;
    o.x = int'(x);   o.y = int'(y);   o.fx = int'(fx); o.fy = int'(fy);
    o.hs = int'(hs); o.vs = int'(vs); o.de = int'(de); o.ls = int'(ls);
    o.fs = int'(fs); o.vb = int'(vb); o.fv = int'(fv);
    return o;
  endfunction

  task automatic cmp(input string tag, input obs_t g, input obs_t e);
    chk({tag, ".x"}, g.x, e.x);
    chk({tag, ".y"}, g.y, e.y);
    chk({tag, ".hsync"}, g.hs, e.hs);
    chk({tag, ".vsync"}, g.vs, e.vs);
    chk({tag, ".de"}, g.de, e.de);
    chk({tag, ".line_start"}, g.ls, e.ls);
    chk({tag, ".frame_start"}, g.fs, e.fs);
    chk({tag, ".vblank"}, g.vb, e.vb);
    chk({tag, ".fetch_valid"}, g.fv, e.fv);
    chk({tag, ".fetch_x"}, g.fx, e.fx);
    chk({tag, ".fetch_y"}, g.fy, e.fy);
  endtask

  // Count rising clock edges since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // Event trackers for interval/length checks
  int a_prev_hs = 1, a_last_ls = -1, a_de_run = 0;
  int b_prev_vs = 1, b_vs_run = 0, b_last_fs = -1, b_de_cnt = 0, b_vbl_lines = 0;
  bit b_first_vs = 1'b1;

  always @(negedge clk) begin
    obs_t ga, gb, gc;
    ga = sample(ifa.x, ifa.y, ifa.fetch_x, ifa.fetch_y, ifa.hsync, ifa.vsync, ifa.de,
                ifa.line_start, ifa.frame_start, ifa.vblank, ifa.fetch_valid);
    gb = sample(ifb.x, ifb.y, ifb.fetch_x, ifb.fetch_y, ifb.hsync, ifb.vsync, ifb.de,
                ifb.line_start, ifb.frame_start, ifb.vblank, ifb.fetch_valid);
    gc = sample(ifc.x, ifc.y, ifc.fetch_x, ifc.fetch_y, ifc.hsync, ifc.vsync, ifc.de,
                ifc.line_start, ifc.frame_start, ifc.vblank, ifc.fetch_valid);
    if (!rst_n) begin
      cmp("rst_a", ga, model(640, 24, 40, 128, 480, 9, 3, 28, 2, 0, 1'b1));
      cmp("rst_b", gb, model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 5, 0, 1'b1));
      cmp("rst_c", gc, model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 2, 0, 1'b1));
      a_prev_hs = 1; a_last_ls = -1; a_de_run = 0;
      b_prev_vs = 1; b_vs_run = 0; b_last_fs = -1; b_de_cnt = 0; b_vbl_lines = 0;
      b_first_vs = 1'b1;
    end else if (edges > 0) begin
      cmp("run_a", ga, model(640, 24, 40, 128, 480, 9, 3, 28, 2, edges - 1, 1'b0));
      cmp("run_b", gb, model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 5, edges - 1, 1'b0));
      cmp("run_c", gc, model(SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 2, edges - 1, 1'b0));

      // Default mode, horizontal: sync edges, line period, visible run length
      if (ga.hs != a_prev_hs) begin
        if (ga.hs == 0) chk("hsync_on_x", ga.x, 664);
        else            chk("hsync_off_x", ga.x, 704);
      end
      a_prev_hs = ga.hs;
      if (ga.ls == 1) begin
        if (a_last_ls >= 0) chk("line_period", edges - a_last_ls, 832);
        a_last_ls = edges;
      end
      if (ga.de == 1) a_de_run++;
      else begin
        if (a_de_run > 0) chk("de_run_len", a_de_run, 640);
        a_de_run = 0;
      end

      // Scaled mode, vertical: frame period, per-frame de count, vblank lines, vsync
      if (gb.fs == 1) begin
        if (b_last_fs >= 0) begin
          chk("frame_period", edges - b_last_fs, 425);
          chk("de_per_frame", b_de_cnt, 160);
          chk("vblank_lines", b_vbl_lines, 7);
        end
        b_last_fs = edges; b_de_cnt = 0; b_vbl_lines = 0;
      end
      b_de_cnt += gb.de;
      if (gb.ls == 1 && gb.vb == 1) b_vbl_lines++;
      if (gb.vs == 0) begin
        if (b_prev_vs == 1) begin
          chk("vsync_start_x", gb.x, 0);
          chk("vsync_start_y", gb.y, 12);
          if (b_first_vs) chk("vsync_after_reset", edges - 1, 300);
          b_first_vs = 1'b0;
        end
        b_vs_run++;
      end else begin
        if (b_prev_vs == 0) chk("vsync_len", b_vs_run, 50);
        b_vs_run = 0;
      end
      b_prev_vs = gb.vs;

      // Fetch wrap at the second-to-last pixel of the frame with LOOKAHEAD 2
      if (gc.x == 23 && gc.y == 16) begin
        chk("wrap_fetch_x", gc.fx, 0);
        chk("wrap_fetch_y", gc.fy, 0);
        chk("wrap_fetch_valid", gc.fv, 1);
      end
    end
  end

  initial begin
    int found;
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b1;

    @(posedge clk);
    #1;
    chk("first_x", int'(ifa.x), 0);
    chk("first_y", int'(ifa.y), 0);
    chk("first_de", int'(ifa.de), 1);
    chk("first_frame_start", int'(ifa.frame_start), 1);
    chk("first_line_start", int'(ifa.line_start), 1);

    repeat (2600) @(posedge clk);

    // Asynchronous reset while the scaled raster is inside both hsync and vsync
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (ifb.x == 10'd19 && ifb.y == 10'd12) found = 1;
    end
    chk("mid_reset_point_reached", found, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_hsync", int'(ifb.hsync), 1);
    chk("mid_reset_vsync", int'(ifb.vsync), 1);
    chk("mid_reset_de", int'(ifb.de), 0);
    chk("mid_reset_x", int'(ifb.x), 0);
    repeat ($urandom_range(1, 4)) @(posedge clk);
    @(negedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b1;
    repeat (900) @(posedge clk);

    // Random asynchronous reset pulses at random raster positions
    repeat (3) begin
      repeat ($urandom_range(100, 700)) @(posedge clk);
      #($urandom_range(1, 4));
      rst_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 3));
      rst_n = 1'b1;
    end
    repeat (1200) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
